// File: rtl/hcf_pkg.sv
// Shared state type, select encodings and defaults for the HCF controller slice.
package hcf_pkg;

    localparam int HCF_ITER_W = 16;

    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_B    = 1'b1;
    localparam logic BUS_SUB  = 1'b0;
    localparam logic BUS_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } hcf_state_e;

    // Odd parity rules out zero and two set; the AND term rules out all three set.
    function automatic logic isOneHot(input logic lt, input logic gt, input logic eq);
        return (lt ^ gt ^ eq) && !(lt && gt && eq);
    endfunction

endpackage

// File: rtl/hcf_iter_counter.sv
// Subtraction counter with synchronous clear/increment and a terminal flag at MAX_ITER.
module hcf_iter_counter
    import hcf_pkg::*;
#(
    parameter int ITER_W   = HCF_ITER_W,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              incr_i,
    output logic [ITER_W-1:0] cnt_o,
    output logic              terminal_o
);

    logic [ITER_W-1:0] cnt_q;
    logic [ITER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (incr_i) begin
            cnt_d = cnt_q + ITER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign terminal_o = (cnt_q == ITER_W'(MAX_ITER));

endmodule

// File: rtl/hcf_controller.sv
// Control FSM for the subtract-and-compare HCF datapath: host handshake,
// operand loading, one subtraction per cycle, and an iteration guard.
module hcf_controller
    import hcf_pkg::*;
#(
    parameter int ITER_W   = HCF_ITER_W,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_cnt
);

    hcf_state_e state_q;
    hcf_state_e state_d;
    logic       cntClear;
    logic       cntIncr;
    logic       atLimit;
    logic       statusOk;

    assign statusOk = isOneHot(lt, gt, eq);

    hcf_iter_counter #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) u_iter_counter (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cntClear),
        .incr_i    (cntIncr),
        .cnt_o     (iter_cnt),
        .terminal_o(atLimit)
    );

    // CHECK outputs are Mealy: they follow the comparator status of the same cycle.
    always_comb begin
        state_d  = state_q;
        ldA      = 1'b0;
        ldB      = 1'b0;
        sel1     = SEL_A;
        sel2     = SEL_A;
        sel_in   = BUS_SUB;
        done     = 1'b0;
        error    = 1'b0;
        cntClear = 1'b0;
        cntIncr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cntClear = 1'b1;
                    state_d  = LOAD_A;
                end
            end
            LOAD_A: begin
                ldA     = 1'b1;
                sel_in  = BUS_DATA;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ldB     = 1'b1;
                sel_in  = BUS_DATA;
                state_d = CHECK;
            end
            CHECK: begin
                if (!statusOk) begin
                    state_d = ERR;
                end else if (eq) begin
                    state_d = DONE;
                end else if (atLimit) begin
                    state_d = ERR;
                end else if (gt) begin
                    ldA     = 1'b1;
                    sel1    = SEL_A;
                    sel2    = SEL_B;
                    sel_in  = BUS_SUB;
                    cntIncr = 1'b1;
                end else begin
                    ldB     = 1'b1;
                    sel1    = SEL_B;
                    sel2    = SEL_A;
                    sel_in  = BUS_SUB;
                    cntIncr = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                error   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_hcf_controller.sv
// Self-checking bench: a bench-side A/B datapath closes the loop around the
// controller, and a per-run schedule model predicts every output cycle.
module tb_hcf_controller;

    localparam int ITER_W   = 16;
    localparam int MAX_ITER = 8;
    localparam int OBS_N    = 256;

    // Output vector order: {ldA, ldB, sel1, sel2, sel_in, busy, done, error}
    localparam logic [7:0] CTL_IDLE  = 8'b0000_0000;
    localparam logic [7:0] CTL_LOADA = 8'b1000_1100;
    localparam logic [7:0] CTL_LOADB = 8'b0100_1100;
    localparam logic [7:0] CTL_BUSY  = 8'b0000_0100;
    localparam logic [7:0] CTL_SUBA  = 8'b1001_0100;
    localparam logic [7:0] CTL_SUBB  = 8'b0110_0100;
    localparam logic [7:0] CTL_DONE  = 8'b0000_0110;
    localparam logic [7:0] CTL_ERR   = 8'b0000_0101;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [15:0] iter;
        logic [15:0] res;
    } expEntry_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic lt;
    logic gt;
    logic eq;
    logic ldA;
    logic ldB;
    logic sel1;
    logic sel2;
    logic sel_in;
    logic busy;
    logic done;
    logic error;
    logic [ITER_W-1:0] iterCnt;

    hcf_controller #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .lt      (lt),
        .gt      (gt),
        .eq      (eq),
        .ldA     (ldA),
        .ldB     (ldB),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel_in  (sel_in),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .iter_cnt(iterCnt)
    );

    always #5 clk = ~clk;

    // Bench-side datapath; injBad forces an illegal lt+gt status.
    logic [15:0] dataIn = '0;
    logic [15:0] dpA = '0;
    logic [15:0] dpB = '0;
    logic [15:0] subOut;
    logic        injBad = 1'b0;

    assign subOut = (sel1 ? dpB : dpA) - (sel2 ? dpB : dpA);
    assign lt = injBad ? 1'b1 : (dpA < dpB);
    assign gt = injBad ? 1'b1 : (dpA > dpB);
    assign eq = injBad ? 1'b0 : (dpA == dpB);

    always @(posedge clk) begin
        if (ldA) dpA <= sel_in ? dataIn : subOut;
        if (ldB) dpB <= sel_in ? dataIn : subOut;
    end

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    bit checkEn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the whole run is scheduled from the operands at the moment start is accepted.
    expEntry_t   expQ[$];
    logic [15:0] heldIter = '0;
    int          curA = 0;
    int          curB = 0;
    int          curInj = -1;

    function automatic void buildRun(input int a, input int b, input int inj);
        int x;
        int y;
        int s;
        expEntry_t e;
        x = a;
        y = b;
        s = 0;
        e = '0;
        e.ctl = CTL_LOADA;
        expQ.push_back(e);
        e.ctl = CTL_LOADB;
        expQ.push_back(e);
        while (1'b1) begin
            e = '0;
            e.iter = 16'(s);
            if (s == inj) begin
                e.ctl = CTL_BUSY; expQ.push_back(e);
                e.ctl = CTL_ERR;  expQ.push_back(e);
                break;
            end
            if (x == y) begin
                e.ctl = CTL_BUSY; expQ.push_back(e);
                e.ctl = CTL_DONE; e.res = 16'(x); expQ.push_back(e);
                break;
            end
            if (s == MAX_ITER) begin
                e.ctl = CTL_BUSY; expQ.push_back(e);
                e.ctl = CTL_ERR;  expQ.push_back(e);
                break;
            end
            if (x > y) begin
                e.ctl = CTL_SUBA;
                x = x - y;
            end else begin
                e.ctl = CTL_SUBB;
                y = y - x;
            end
            expQ.push_back(e);
            s++;
        end
    endfunction

    logic [7:0]  obsCtl [OBS_N];
    logic [15:0] obsIter[OBS_N];
    logic [15:0] obsA   [OBS_N];

    // Compare every cycle, then advance the model on the inputs the DUT will sample next edge.
    always @(negedge clk) begin : compareProc
        expEntry_t  e;
        logic [7:0] act;
        bit         wasIdle;
        if (checkEn) begin
            if (expQ.size() > 0) begin
                e = expQ[0];
            end else begin
                e = '0;
                e.iter = heldIter;
            end
            act = {ldA, ldB, sel1, sel2, sel_in, busy, done, error};
            check("ctl", 32'(act), 32'(e.ctl));
            check("iter_cnt", 32'(iterCnt), 32'(e.iter));
            if (e.ctl == CTL_DONE) check("result", 32'(dpA), 32'(e.res));
            obsCtl[cyc % OBS_N]  = act;
            obsIter[cyc % OBS_N] = iterCnt;
            obsA[cyc % OBS_N]    = dpA;
            wasIdle = (expQ.size() == 0);
            if (rst) begin
                expQ.delete();
                heldIter = '0;
            end else if (!wasIdle) begin
                heldIter = expQ[0].iter;
                void'(expQ.pop_front());
            end else if (start) begin
                buildRun(curA, curB, curInj);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        start = 1'b0;
        repeat (n) tick();
    endtask

    // Entered and left at 1 time unit after a rising edge in an idle cycle.
    task automatic applyStimulus(input int a, input int b, input int inj, input logic [31:0] strayMask,
                                 input bit hold, input int rstAt, output int c0);
        int idx;
        c0     = cyc;
        curA   = a;
        curB   = b;
        curInj = inj;
        rst    = 1'b0;
        injBad = 1'b0;
        start  = 1'b1;
        dataIn = 16'($urandom);
        tick();
        idx = 1;
        while (expQ.size() != 0 && idx < 100) begin
            rst    = (idx == rstAt);
            start  = ((idx < 32) && strayMask[idx]) || (hold && expQ.size() == 1);
            dataIn = (idx == 1) ? 16'(a) : (idx == 2) ? 16'(b) : 16'($urandom);
            injBad = (inj >= 0) && (idx == 3 + inj);
            tick();
            idx++;
        end
        if (idx >= 100) check("run_bound", 32'(idx), 32'(99));
        rst    = 1'b0;
        injBad = 1'b0;
        start  = hold;
    endtask

    task automatic checkOutput(input string name, input int c0, input int k,
                               input logic [7:0] expCtl);
        check(name, 32'(obsCtl[(c0 + k) % OBS_N]), 32'(expCtl));
    endtask

    task automatic checkIter(input string name, input int c0, input int k, input int expIter);
        check(name, 32'(obsIter[(c0 + k) % OBS_N]), 32'(expIter));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int c0;
        int c1;
        int ldaCount;
        int doneCount;
        int a;
        int b;
        int inj;
        int rstAt;
        bit hold;
        logic [31:0] mask;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        checkEn = 1'b1;
        c0 = cyc;
        tick();
        checkOutput("reset_ctl", c0, 0, CTL_IDLE);
        checkIter("reset_iter", c0, 0, 0);
        rst = 1'b0;
        idleCycles(2);

        // Equal operands: no subtraction, done in cycle 4.
        applyStimulus(7, 7, -1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        checkOutput("eq_c1_loadA", c0, 1, CTL_LOADA);
        checkOutput("eq_c2_loadB", c0, 2, CTL_LOADB);
        checkOutput("eq_c3_check", c0, 3, CTL_BUSY);
        checkOutput("eq_c4_done", c0, 4, CTL_DONE);
        checkIter("eq_c4_iter", c0, 4, 0);
        checkOutput("eq_c5_idle", c0, 5, CTL_IDLE);

        // 12,18: B<=6 then A<=6, done in cycle 6.
        applyStimulus(12, 18, -1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        checkOutput("g12_c3_subB", c0, 3, CTL_SUBB);
        checkOutput("g12_c4_subA", c0, 4, CTL_SUBA);
        checkOutput("g12_c6_done", c0, 6, CTL_DONE);
        checkIter("g12_c6_iter", c0, 6, 2);
        check("g12_result", 32'(obsA[(c0 + 6) % OBS_N]), 32'd6);

        // Zero operand never converges: 8 subtractions then error in cycle 12.
        applyStimulus(13, 0, -1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        ldaCount  = 0;
        doneCount = 0;
        for (int k = 0; k <= 13; k++) begin
            ldaCount  += int'(obsCtl[(c0 + k) % OBS_N][7] & ~obsCtl[(c0 + k) % OBS_N][3] ? 0 : 0);
            ldaCount  += int'(obsCtl[(c0 + k) % OBS_N] == CTL_SUBA);
            doneCount += int'(obsCtl[(c0 + k) % OBS_N][1]);
        end
        check("tmo_subA_count", 32'(ldaCount), 32'd8);
        check("tmo_done_count", 32'(doneCount), 32'd0);
        checkOutput("tmo_c12_err", c0, 12, CTL_ERR);
        checkIter("tmo_c12_iter", c0, 12, 8);

        // Exactly MAX_ITER subtractions still ends in done.
        applyStimulus(9, 1, -1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        checkOutput("lim_c12_done", c0, 12, CTL_DONE);
        checkIter("lim_c12_iter", c0, 12, 8);

        // Illegal lt+gt status in the second CHECK cycle.
        applyStimulus(5, 3, 1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        checkOutput("inj_c3_subA", c0, 3, CTL_SUBA);
        checkOutput("inj_c4_noload", c0, 4, CTL_BUSY);
        checkOutput("inj_c5_err", c0, 5, CTL_ERR);
        checkOutput("inj_c6_idle", c0, 6, CTL_IDLE);

        // Reset during CHECK abandons the run; a fresh run then completes.
        applyStimulus(9, 6, -1, 32'h0, 1'b0, 4, c0);
        idleCycles(1);
        checkOutput("rst_c5_idle", c0, 5, CTL_IDLE);
        checkIter("rst_c5_iter", c0, 5, 0);
        applyStimulus(9, 6, -1, 32'h0, 1'b0, -1, c0);
        idleCycles(1);
        checkOutput("after_rst_done", c0, 6, CTL_DONE);
        checkIter("after_rst_iter", c0, 6, 2);
        check("after_rst_result", 32'(obsA[(c0 + 6) % OBS_N]), 32'd3);

        // Stray starts in LOAD_B and CHECK, then start held through DONE.
        applyStimulus(12, 18, -1, 32'h0000_0014, 1'b1, -1, c0);
        applyStimulus(7, 7, -1, 32'h0, 1'b0, -1, c1);
        idleCycles(1);
        checkOutput("stray_c2_loadB", c0, 2, CTL_LOADB);
        checkOutput("stray_c4_subA", c0, 4, CTL_SUBA);
        checkOutput("stray_c6_done", c0, 6, CTL_DONE);
        checkOutput("hold_c7_idle", c0, 7, CTL_IDLE);
        checkOutput("hold_c8_loadA", c0, 8, CTL_LOADA);
        checkOutput("hold_run2_done", c0, 11, CTL_DONE);

        // Randomised runs against the model.
        for (int r = 0; r < 200; r++) begin
            a     = int'($urandom_range(0, 20));
            b     = int'($urandom_range(0, 20));
            inj   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            mask  = $urandom & $urandom & 32'hFFFF_FFFE;
            hold  = ($urandom_range(0, 2) == 0);
            rstAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : -1;
            applyStimulus(a, b, inj, mask, hold, rstAt, c0);
            if (!hold) idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
